// File: rtl/systolic_deskew_drain.sv
// systolic_deskew_drain: streams a skewed result buffer out as de-skewed rows with ready/valid backpressure.
module systolic_deskew_drain #(
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE = 32,
  parameter int ROWS = 512,
  parameter int DEPTH = 543,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [DATAWIDTH_output*N_SIZE-1:0] buf_rd_data,
  output logic [DATAWIDTH_output*N_SIZE-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done
);
  localparam int W = DATAWIDTH_output;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] a_cnt, d_addr;
  logic d_vld;
  logic [RW-1:0] row_cnt;
  logic adv, iss, last_iss, ing, fire, last_fire;
  logic [W*N_SIZE-1:0] col;
  assign adv       = !out_valid || out_ready;
  assign iss       = adv && state == DRAIN;
  assign last_iss  = iss && a_cnt == ADDR_WIDTH'(DEPTH-1);
  assign ing       = adv && d_vld;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && row_cnt == RW'(ROWS-1);
  // On a stall, re-present the address whose data is on the bus so the next cycle sees the same word.
  assign rd_addr   = adv ? a_cnt : d_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE)  ? (start ? DRAIN : IDLE) :
                (state == DRAIN) ? (last_iss ? FLUSH : DRAIN) :
                (last_fire ? IDLE : FLUSH);
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_cnt     <= '0;
      d_addr    <= '0;
      d_vld     <= 1'b0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      if (adv) begin
        d_vld     <= iss;
        d_addr    <= a_cnt;
        out_valid <= ing && d_addr >= ADDR_WIDTH'(N_SIZE-1);
      end
      if (iss) a_cnt <= last_iss ? '0 : a_cnt + 1'b1;
      if (fire) row_cnt <= last_fire ? '0 : row_cnt + 1'b1;
      if (ing) out_data <= col;
      done <= state == FLUSH && last_fire;
    end
  // Column j is delayed by N_SIZE-1-j ingests so every column lines up on the same row.
  for (genvar j = 0; j < N_SIZE; j++) begin : g_col
    localparam int D = N_SIZE - 1 - j;
    if (D == 0) begin : g_pass
      assign col[j*W +: W] = buf_rd_data[j*W +: W];
    end else begin : g_dly
      logic [W-1:0] sr [D];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else if (ing) begin
          sr[0] <= buf_rd_data[j*W +: W];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      assign col[j*W +: W] = sr[D-1];
    end
  end
endmodule

// File: tb/tb_systolic_deskew_drain.sv
// tb_systolic_deskew_drain: scoreboard bench for the deskew drain on a 4-column, 8-row buffer.
module tb_systolic_deskew_drain;
  localparam int W = 32, N = 4, ROWS = 8, DEPTH = 11, AW = 4;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [AW-1:0] rd_addr;
  logic [W*N-1:0] buf_rd_data = '0, out_data;
  logic out_valid, busy, done;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  logic [W*N-1:0] exp_q [$];

  systolic_deskew_drain #(.DATAWIDTH_output(W), .N_SIZE(N), .ROWS(ROWS), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .buf_rd_data(buf_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [W*N-1:0] word(int a);
    logic [W*N-1:0] w = '0;
    for (int j = 0; j < N; j++)
      if (a - j >= 0 && a - j < ROWS) w[j*W +: W] = 32'(16 * (a - j) + j);
    return w;
  endfunction

  function automatic logic [W*N-1:0] row(int r);
    logic [W*N-1:0] w;
    for (int j = 0; j < N; j++) w[j*W +: W] = 32'(16 * r + j);
    return w;
  endfunction

  always @(posedge clk) buf_rd_data <= word(int'(rd_addr));

  task automatic chk(string name, logic [W*N-1:0] act, logic [W*N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stalls hold and done follows the last row.
  logic pv = 0, pr = 0, plf = 0, lf;
  logic [W*N-1:0] pd = '0, e;
  int seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0; pr = 0; plf = 0; seen = 0;
    end else begin
      if (done || plf) chk("done_pulse", done, plf);
      if (done) done_cnt++;
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      lf = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_row: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", out_data, e);
        end
        lf = seen == ROWS - 1;
        seen = lf ? 0 : seen + 1;
      end
      plf = lf; pv = out_valid; pr = out_ready; pd = out_data;
    end
  end

  task automatic push_drain();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(row(r));
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1;
    push_drain();
    @(posedge clk); #1;
    start = 0;
  endtask

  // mode 0: ready high with timing checks; 1: stall pattern; 2: stray starts plus restart in done cycle; 3: random ready
  task automatic run(int mode, int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      out_ready = (mode == 1) ? !(c inside {7, 8, 9, 12}) :
                  (mode == 3) ? ($urandom_range(0, 99) < 30) : 1'b1;
      start = (mode == 2) && (c inside {3, 12, 14});
      if (mode == 2 && c == 14) push_drain();
      @(negedge clk);
      if (mode == 0) begin
        if (c <= 11) chk($sformatf("rd_addr_c%0d", c), rd_addr, c - 1);
        chk($sformatf("valid_c%0d", c), out_valid, c >= 6 && c <= 13);
        chk($sformatf("busy_c%0d", c), busy, c <= 13);
        chk($sformatf("done_c%0d", c), done, c == 14);
      end
      if (mode == 1 && c >= 7 && c <= 10) begin
        chk($sformatf("stall_valid_c%0d", c), out_valid, 1);
        chk($sformatf("stall_row1_c%0d", c), out_data, row(1));
      end
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_finished", k < 500, 1);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    do_start();
    run(0, 15);
    wait_idle();
    do_start();
    run(1, 15);
    wait_idle();
    do_start();
    run(2, 30);
    wait_idle();
    do_start();
    run(0, 8);
    @(negedge clk); #2 rst_n = 0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_reset_valid", out_valid, 0);
      chk("post_reset_busy", busy, 0);
    end
    do_start();
    run(3, 120);
    wait_idle();
    chk("done_count", done_cnt, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
